stepdir_generator: RTL and testbench

Motion-command front end that produces the STEP/DIR pulse stream consumed by the team's 4-phase step/dir coil drivers. Accepts a signed absolute target position and a step period over a valid/ready handshake. Emits one STEP pulse per position unit with guaranteed DIR setup and pulse width, tracks the commanded position, and reports completion.

---
 rtl/stepdir_pkg.sv | 14 +
 rtl/stepdir_generator.sv | 158 +++++++++++++++
 tb/tb_stepdir_generator.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/stepdir_pkg.sv
// Shared definitions for the step/dir pulse generator: FSM states and DIR encoding.
package stepdir_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDsetup,
    StStepHi,
    StStepLo
  } state_e;

  localparam logic DIR_INC = 1'b1;
  localparam logic DIR_DEC = 1'b0;

endpackage

// File: rtl/stepdir_generator.sv
// Step/dir motion front end: accepts absolute targets and emits timed STEP pulses toward them.
module stepdir_generator
  import stepdir_pkg::*;
#(
  parameter int unsigned POS_W     = 16,
  parameter int unsigned PER_W     = 16,
  parameter int unsigned PULSE_W   = 4,
  parameter int unsigned DIR_SETUP = 3
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    CMD_VALID,
  output logic                    CMD_READY,
  input  logic signed [POS_W-1:0] CMD_TARGET,
  input  logic        [PER_W-1:0] CMD_PERIOD,
  input  logic                    STOP,
  input  logic                    SET_POS,
  input  logic signed [POS_W-1:0] SET_VAL,
  output logic                    STEP,
  output logic                    DIR,
  output logic signed [POS_W-1:0] POSITION,
  output logic                    BUSY,
  output logic                    DONE
);

  localparam logic [PER_W-1:0] PulseLoad  = PER_W'(PULSE_W - 1);
  localparam logic [PER_W-1:0] DsetupLoad = PER_W'(DIR_SETUP - 1);
  localparam logic [PER_W-1:0] MinPer     = PER_W'(2 * PULSE_W);
  localparam logic [PER_W-1:0] LoOffset   = PER_W'(PULSE_W + 1);

  state_e                    state_q, state_d;
  logic        [PER_W-1:0]   cnt_q, cnt_d;
  logic        [PER_W-1:0]   per_q, per_d;
  logic signed [POS_W-1:0]   pos_q, pos_d;
  logic signed [POS_W-1:0]   target_q, target_d;
  logic                      dir_q, dir_d;
  logic                      step_q, step_d;
  logic                      done_q, done_d;
  logic                      stop_q, stop_d;

  logic                      dir_req;
  logic signed [POS_W-1:0]   pos_step;

  assign dir_req  = (CMD_TARGET > pos_q) ? DIR_INC : DIR_DEC;
  // Valid in DSETUP too, since DIR is committed on the transition into it.
  assign pos_step = (dir_q == DIR_INC) ? pos_q + POS_W'(1) : pos_q - POS_W'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    per_d    = per_q;
    pos_d    = pos_q;
    target_d = target_q;
    dir_d    = dir_q;
    step_d   = step_q;
    done_d   = 1'b0;
    stop_d   = stop_q;

    if (state_q != StIdle && STOP) begin
      stop_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (SET_POS) begin
          pos_d = SET_VAL;
        end else if (CMD_VALID) begin
          target_d = CMD_TARGET;
          per_d    = (CMD_PERIOD < MinPer) ? MinPer : CMD_PERIOD;
          stop_d   = 1'b0;
          if (CMD_TARGET == pos_q) begin
            done_d = 1'b1;
          end else if (dir_req != dir_q) begin
            dir_d   = dir_req;
            state_d = StDsetup;
            cnt_d   = DsetupLoad;
          end else begin
            state_d = StStepHi;
            step_d  = 1'b1;
            cnt_d   = PulseLoad;
            pos_d   = pos_step;
          end
        end
      end

      StDsetup: begin
        if (cnt_q == '0) begin
          state_d = StStepHi;
          step_d  = 1'b1;
          cnt_d   = PulseLoad;
          pos_d   = pos_step;
        end else begin
          cnt_d = cnt_q - PER_W'(1);
        end
      end

      StStepHi: begin
        if (cnt_q == '0) begin
          state_d = StStepLo;
          step_d  = 1'b0;
          cnt_d   = per_q - LoOffset;
        end else begin
          cnt_d = cnt_q - PER_W'(1);
        end
      end

      StStepLo: begin
        if (cnt_q == '0) begin
          if (pos_q == target_q || stop_q) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StStepHi;
            step_d  = 1'b1;
            cnt_d   = PulseLoad;
            pos_d   = pos_step;
          end
        end else begin
          cnt_d = cnt_q - PER_W'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      per_q    <= '0;
      pos_q    <= '0;
      target_q <= '0;
      dir_q    <= DIR_INC;
      step_q   <= 1'b0;
      done_q   <= 1'b0;
      stop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      per_q    <= per_d;
      pos_q    <= pos_d;
      target_q <= target_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
      done_q   <= done_d;
      stop_q   <= stop_d;
    end
  end

  assign CMD_READY = (state_q == StIdle) && !SET_POS;
  assign BUSY      = (state_q != StIdle);
  assign STEP      = step_q;
  assign DIR       = dir_q;
  assign POSITION  = pos_q;
  assign DONE      = done_q;

endmodule

// File: tb/tb_stepdir_generator.sv
// Directed self-checking bench for stepdir_generator with a negedge pulse monitor.
module tb_stepdir_generator;

  logic               CLK;
  logic               RESET_N;
  logic               CMD_VALID;
  logic               CMD_READY;
  logic signed [15:0] CMD_TARGET;
  logic        [15:0] CMD_PERIOD;
  logic               STOP;
  logic               SET_POS;
  logic signed [15:0] SET_VAL;
  logic               STEP;
  logic               DIR;
  logic signed [15:0] POSITION;
  logic               BUSY;
  logic               DONE;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc;
  logic step_prev = 1'b0;

  int rise_c[$];
  int rise_p[$];
  int wid[$];
  int done_c[$];

  stepdir_generator #(
    .POS_W(16), .PER_W(16), .PULSE_W(4), .DIR_SETUP(3)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_TARGET(CMD_TARGET), .CMD_PERIOD(CMD_PERIOD), .STOP(STOP), .SET_POS(SET_POS),
    .SET_VAL(SET_VAL), .STEP(STEP), .DIR(DIR), .POSITION(POSITION), .BUSY(BUSY),
    .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (STEP && !step_prev) begin
      rise_c.push_back(cyc);
      rise_p.push_back(int'(POSITION));
    end
    if (!STEP && step_prev && rise_c.size() > 0) wid.push_back(cyc - rise_c[$]);
    if (DONE) done_c.push_back(cyc);
    step_prev = STEP;
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_log();
    rise_c.delete();
    rise_p.delete();
    wid.delete();
    done_c.delete();
  endtask

  // Issue a one-cycle command; acc holds the cycle number of the accepting edge.
  task automatic issue(input logic signed [15:0] tgt, input logic [15:0] per);
    CMD_TARGET = tgt;
    CMD_PERIOD = per;
    CMD_VALID  = 1'b1;
    tick();
    acc       = cyc;
    CMD_VALID = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lim);
    int i;
    for (i = 0; i < lim; i++) begin
      tick();
      if (DONE) break;
    end
    if (i == lim) chk({tag, "_timeout"}, 0, 1);
    tick();
    tick();
  endtask

  initial begin
    RESET_N    = 1'b0;
    CMD_VALID  = 1'b0;
    CMD_TARGET = '0;
    CMD_PERIOD = '0;
    STOP       = 1'b0;
    SET_POS    = 1'b0;
    SET_VAL    = '0;
    #23;
    chk("rst_step", 32'(STEP), 0);
    chk("rst_dir", 32'(DIR), 1);
    chk("rst_pos", POSITION, 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_done", 32'(DONE), 0);
    tick();
    RESET_N = 1'b1;
    tick();
    chk("idle_ready", 32'(CMD_READY), 1);

    // Forward move, no DIR change
    clear_log();
    issue(16'sd3, 16'd10);
    chk("t1_busy", 32'(BUSY), 1);
    chk("t1_ready_busy", 32'(CMD_READY), 0);
    wait_done("t1", 100);
    chk("t1_rises", rise_c.size(), 3);
    if (rise_c.size() == 3 && wid.size() == 3) begin
      chk("t1_first_rise", rise_c[0] - acc, 0);
      chk("t1_pos0", rise_p[0], 1);
      chk("t1_pos1", rise_p[1], 2);
      chk("t1_pos2", rise_p[2], 3);
      chk("t1_wid0", wid[0], 4);
      chk("t1_wid2", wid[2], 4);
      chk("t1_space01", rise_c[1] - rise_c[0], 10);
      chk("t1_space12", rise_c[2] - rise_c[1], 10);
    end
    chk("t1_done_cnt", done_c.size(), 1);
    if (done_c.size() == 1 && rise_c.size() == 3)
      chk("t1_done_time", done_c[0] - rise_c[2], 10);
    chk("t1_dir", 32'(DIR), 1);
    chk("t1_pos", POSITION, 3);
    chk("t1_idle", 32'(BUSY), 0);

    // Reverse move with DIR setup
    clear_log();
    issue(-16'sd2, 16'd8);
    chk("t2_dir_fell", 32'(DIR), 0);
    chk("t2_step_low", 32'(STEP), 0);
    wait_done("t2", 200);
    chk("t2_rises", rise_c.size(), 5);
    if (rise_c.size() == 5) begin
      chk("t2_setup", rise_c[0] - acc, 3);
      chk("t2_pos_first", rise_p[0], 2);
      chk("t2_pos_last", rise_p[4], -2);
      chk("t2_space", rise_c[4] - rise_c[3], 8);
    end
    chk("t2_done_cnt", done_c.size(), 1);
    chk("t2_pos", POSITION, -2);

    // Period below 2*PULSE_W is raised to 8
    clear_log();
    issue(16'sd0, 16'd2);
    chk("t3_dir_rose", 32'(DIR), 1);
    wait_done("t3", 100);
    chk("t3_rises", rise_c.size(), 2);
    if (rise_c.size() == 2 && wid.size() == 2) begin
      chk("t3_setup", rise_c[0] - acc, 3);
      chk("t3_wid", wid[0], 4);
      chk("t3_space", rise_c[1] - rise_c[0], 8);
    end
    if (done_c.size() == 1 && rise_c.size() == 2)
      chk("t3_done_time", done_c[0] - rise_c[1], 8);
    chk("t3_pos", POSITION, 0);

    // STOP during the 5th pulse
    clear_log();
    issue(16'sd100, 16'd10);
    begin
      int k;
      for (k = 0; k < 200; k++) begin
        if (STEP && POSITION == 16'sd5) break;
        tick();
      end
      if (k == 200) chk("t4_reach5_timeout", 0, 1);
    end
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
    chk("t4_step_held", 32'(STEP), 1);
    wait_done("t4", 100);
    chk("t4_rises", rise_c.size(), 5);
    if (wid.size() == 5) chk("t4_last_wid", wid[4], 4);
    chk("t4_pos", POSITION, 5);
    chk("t4_done_cnt", done_c.size(), 1);
    chk("t4_ready", 32'(CMD_READY), 1);

    // SET_POS beats CMD_VALID
    clear_log();
    SET_POS    = 1'b1;
    SET_VAL    = 16'sd50;
    CMD_VALID  = 1'b1;
    CMD_TARGET = 16'sd7;
    CMD_PERIOD = 16'd10;
    #1;
    chk("t5_ready_setpos", 32'(CMD_READY), 0);
    tick();
    SET_POS   = 1'b0;
    CMD_VALID = 1'b0;
    chk("t5_pos", POSITION, 50);
    chk("t5_not_busy", 32'(BUSY), 0);
    tick();
    chk("t5_still_idle", 32'(BUSY), 0);
    issue(16'sd50, 16'd10);
    chk("t5_done", 32'(DONE), 1);
    chk("t5_nobusy", 32'(BUSY), 0);
    tick();
    chk("t5_done_once", 32'(DONE), 0);
    chk("t5_no_step", rise_c.size(), 0);

    // Asynchronous reset mid-pulse
    clear_log();
    issue(16'sd60, 16'd10);
    chk("t6_step_hi", 32'(STEP), 1);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("t6_rst_step", 32'(STEP), 0);
    chk("t6_rst_pos", POSITION, 0);
    chk("t6_rst_busy", 32'(BUSY), 0);
    chk("t6_rst_dir", 32'(DIR), 1);
    tick();
    RESET_N = 1'b1;
    tick();
    chk("t6_ready", 32'(CMD_READY), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
